ctrl_unit: RTL and testbench

- Fetch/decode/execute sequencer for the 8-bit accumulator datapath; sits directly upstream of the ALU.
- Owns PC, IR, ACC and the Z/C flag register.
- Drives the ALU operands and 3-bit op-select, consumes the ALU result and flags, and drives the sync-read instruction and data memories.
- Each instruction takes 3 cycles.

---
 rtl/ctrl_pkg.sv | 53 +++++
 rtl/ctrl_decode.sv | 64 ++++++
 rtl/ctrl_unit.sv | 141 ++++++++++++++
 tb/tb_ctrl_unit.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared constants and types for the accumulator-machine sequencer.
//   - 4-bit opcode values (IR[11:8])
//   - 3-bit ALU op-select codes as understood by the downstream ALU
//   - FSM state encoding and decode-bundle types used by ctrl_unit/ctrl_decode
package ctrl_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_SHL  = 4'h6;
  localparam logic [3:0] OP_SHR  = 4'h7;
  localparam logic [3:0] OP_LDI  = 4'h8;
  localparam logic [3:0] OP_LDA  = 4'h9;
  localparam logic [3:0] OP_STA  = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_JZ   = 4'hC;
  localparam logic [3:0] OP_JC   = 4'hD;
  localparam logic [3:0] OP_ADDI = 4'hE;
  localparam logic [3:0] OP_HLT  = 4'hF;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SHL = 3'b101;
  localparam logic [2:0] ALU_SHR = 3'b110;

  typedef enum logic [1:0] {ST_FETCH, ST_DECODE, ST_EXECUTE, ST_HALT} state_t;

  // ALU operand b source
  typedef enum logic [1:0] {BSEL_ZERO, BSEL_MEM, BSEL_ACC, BSEL_IMM} bsel_t;

  // accumulator writeback source
  typedef enum logic [1:0] {ASRC_ALU, ASRC_IMM, ASRC_MEM} asrc_t;

  typedef enum logic [1:0] {JMP_NONE, JMP_ALWAYS, JMP_Z, JMP_C} jump_t;

  typedef struct packed {
    logic [2:0] alu_opr;
    bsel_t      bsel;
    logic       acc_we;
    asrc_t      acc_src;
    logic       flag_we;
    logic       mem_we_req;
    jump_t      jump;
    logic       halt;
  } dec_t;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational opcode decoder.
// Ports:
//   i_opcode  in  4   IR[11:8]
//   o_dec     out     control bundle (ALU op, operand-b select, ACC/flag
//                     writeback enables, store request, jump kind, halt)
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [3:0] i_opcode,
  output dec_t       o_dec
);

  always_comb begin
    o_dec.alu_opr    = ALU_ADD;
    o_dec.bsel       = BSEL_ZERO;
    o_dec.acc_we     = 1'b0;
    o_dec.acc_src    = ASRC_ALU;
    o_dec.flag_we    = 1'b0;
    o_dec.mem_we_req = 1'b0;
    o_dec.jump       = JMP_NONE;
    o_dec.halt       = 1'b0;
    case (i_opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
        o_dec.bsel    = BSEL_MEM;
        o_dec.acc_we  = 1'b1;
        o_dec.flag_we = 1'b1;
        case (i_opcode)
          OP_SUB:  o_dec.alu_opr = ALU_SUB;
          OP_AND:  o_dec.alu_opr = ALU_AND;
          OP_OR:   o_dec.alu_opr = ALU_OR;
          OP_XOR:  o_dec.alu_opr = ALU_XOR;
          default: o_dec.alu_opr = ALU_ADD;
        endcase
      end
      // shifts operate on ACC routed through operand b
      OP_SHL, OP_SHR: begin
        o_dec.bsel    = BSEL_ACC;
        o_dec.acc_we  = 1'b1;
        o_dec.flag_we = 1'b1;
        o_dec.alu_opr = (i_opcode == OP_SHL) ? ALU_SHL : ALU_SHR;
      end
      OP_ADDI: begin
        o_dec.bsel    = BSEL_IMM;
        o_dec.acc_we  = 1'b1;
        o_dec.flag_we = 1'b1;
      end
      OP_LDI: begin
        o_dec.acc_we  = 1'b1;
        o_dec.acc_src = ASRC_IMM;
      end
      OP_LDA: begin
        o_dec.acc_we  = 1'b1;
        o_dec.acc_src = ASRC_MEM;
      end
      OP_STA:  o_dec.mem_we_req = 1'b1;
      OP_JMP:  o_dec.jump       = JMP_ALWAYS;
      OP_JZ:   o_dec.jump       = JMP_Z;
      OP_JC:   o_dec.jump       = JMP_C;
      OP_HLT:  o_dec.halt       = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/ctrl_unit.sv
// ctrl_unit: 3-cycle fetch/decode/execute sequencer for the 8-bit
// accumulator datapath. Owns PC, IR, ACC and Z/C; drives the external ALU
// and the sync-read instruction/data memories.
// Ports:
//   clk, rst            clock (rising), async active-high reset
//   en                  1 = advance, 0 = freeze everything, no store
//   instr_addr/data     instruction ROM address (=PC) / word (1-cycle latency)
//   mem_addr/rdata      data memory address / read data (1-cycle latency)
//   mem_wdata/we        data memory write data (=ACC) / write enable
//   alu_a/b/opr         ALU operands and op-select
//   alu_y/z/c           ALU result, zero flag, carry/borrow
//   acc, flag_z/c       debug view of ACC and registered flags
//   halted              high while in HALT
module ctrl_unit
  import ctrl_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [7:0]  instr_addr,
  input  logic [11:0] instr_data,
  output logic [7:0]  mem_addr,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_opr,
  input  logic [7:0]  alu_y,
  input  logic        alu_z,
  input  logic        alu_c,
  output logic [7:0]  acc,
  output logic        flag_z,
  output logic        flag_c,
  output logic        halted
);

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_pc, w_pc_nxt;
  logic [11:0] r_ir, w_ir_nxt;
  logic [7:0]  r_acc, w_acc_nxt;
  logic        r_z, w_z_nxt;
  logic        r_c, w_c_nxt;
  dec_t        w_dec;
  logic        w_take;

  ctrl_decode u_dec (
    .i_opcode (r_ir[11:8]),
    .o_dec    (w_dec)
  );

  assign instr_addr = r_pc;
  assign alu_a      = r_acc;
  assign mem_wdata  = r_acc;
  assign acc        = r_acc;
  assign flag_z     = r_z;
  assign flag_c     = r_c;
  assign halted     = (r_state == ST_HALT);
  assign alu_opr    = w_dec.alu_opr;

  always_comb begin
    case (w_dec.bsel)
      BSEL_MEM: alu_b = mem_rdata;
      BSEL_ACC: alu_b = r_acc;
      BSEL_IMM: alu_b = r_ir[7:0];
      default:  alu_b = 8'h00;
    endcase
  end

  // branch conditions use the flags as they stood before this instruction
  always_comb begin
    case (w_dec.jump)
      JMP_ALWAYS: w_take = 1'b1;
      JMP_Z:      w_take = r_z;
      JMP_C:      w_take = r_c;
      default:    w_take = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ir_nxt    = r_ir;
    w_acc_nxt   = r_acc;
    w_z_nxt     = r_z;
    w_c_nxt     = r_c;
    mem_addr    = r_ir[7:0];
    mem_we      = 1'b0;
    case (r_state)
      ST_FETCH: w_state_nxt = ST_DECODE;
      ST_DECODE: begin
        w_ir_nxt    = instr_data;
        // address straight from ROM output so read data is ready in EXECUTE
        mem_addr    = instr_data[7:0];
        w_state_nxt = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        mem_we = w_dec.mem_we_req & en;
        if (w_dec.acc_we) begin
          case (w_dec.acc_src)
            ASRC_IMM: w_acc_nxt = r_ir[7:0];
            ASRC_MEM: w_acc_nxt = mem_rdata;
            default:  w_acc_nxt = alu_y;
          endcase
        end
        if (w_dec.flag_we) begin
          w_z_nxt = alu_z;
          w_c_nxt = alu_c;
        end
        if (w_dec.halt) begin
          w_state_nxt = ST_HALT;
        end else begin
          w_pc_nxt    = w_take ? r_ir[7:0] : r_pc + 8'd1;
          w_state_nxt = ST_FETCH;
        end
      end
      default: ;  // HALT: only reset leaves
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_FETCH;
      r_pc    <= RESET_PC;
      r_ir    <= 12'h000;
      r_acc   <= 8'h00;
      r_z     <= 1'b0;
      r_c     <= 1'b0;
    end else if (en) begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_ir    <= w_ir_nxt;
      r_acc   <= w_acc_nxt;
      r_z     <= w_z_nxt;
      r_c     <= w_c_nxt;
    end
  end

endmodule

// File: tb/tb_ctrl_unit.sv
module tb_ctrl_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b1;
  logic [7:0]  instr_addr;
  logic [11:0] instr_data;
  logic [7:0]  mem_addr, mem_rdata, mem_wdata;
  logic        mem_we;
  logic [7:0]  alu_a, alu_b, alu_y;
  logic [2:0]  alu_opr;
  logic        alu_z, alu_c;
  logic [7:0]  acc;
  logic        flag_z, flag_c, halted;

  int total = 0;
  int bad   = 0;

  logic [11:0] rom [256];
  logic [7:0]  ram_init [256];
  logic [7:0]  ram [256];

  always #5 clk = ~clk;

  ctrl_unit dut (
    .clk(clk), .rst(rst), .en(en),
    .instr_addr(instr_addr), .instr_data(instr_data),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_wdata(mem_wdata), .mem_we(mem_we),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opr(alu_opr),
    .alu_y(alu_y), .alu_z(alu_z), .alu_c(alu_c),
    .acc(acc), .flag_z(flag_z), .flag_c(flag_c), .halted(halted)
  );

  // environment: external ALU
  logic [8:0] alu_r;
  always_comb begin
    case (alu_opr)
      3'd0:    alu_r = {1'b0, alu_a} + {1'b0, alu_b};
      3'd1:    alu_r = {1'b0, alu_a} - {1'b0, alu_b};
      3'd2:    alu_r = {1'b0, alu_a & alu_b};
      3'd3:    alu_r = {1'b0, alu_a | alu_b};
      3'd4:    alu_r = {1'b0, alu_a ^ alu_b};
      3'd5:    alu_r = {alu_b, 1'b0};
      3'd6:    alu_r = {2'b00, alu_b[7:1]};
      default: alu_r = 9'h000;
    endcase
    alu_y = alu_r[7:0];
    alu_c = alu_r[8];
    alu_z = (alu_r[7:0] == 8'h00);
  end

  // environment: sync ROM and RAM; RAM is (re)loaded while reset is held
  always @(posedge clk) begin
    instr_data <= rom[instr_addr];
    mem_rdata  <= ram[mem_addr];
    if (rst) ram <= ram_init;
    else if (mem_we) ram[mem_addr] <= mem_wdata;
  end

  int         we_cnt = 0;
  logic [7:0] we_addr, we_data;
  always @(negedge clk) begin
    if (mem_we) begin
      we_cnt++;
      we_addr = mem_addr;
      we_data = mem_wdata;
    end
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", n, a, e, $time);
    end
  endtask

  // ---------------- instruction-level reference model ----------------
  int         m_phase;
  logic [7:0] m_pc, m_acc, m_ram [256];
  logic       m_z, m_c, m_halt;
  logic [11:0] m_iw;
  logic [3:0]  m_op;
  logic [7:0]  m_k;
  logic [8:0]  m_s;
  logic        m_alu, m_jmp;

  function automatic logic [2:0] exp_opr(input logic [3:0] op);
    case (op)
      4'h2: return 3'd1;
      4'h3: return 3'd2;
      4'h4: return 3'd3;
      4'h5: return 3'd4;
      4'h6: return 3'd5;
      4'h7: return 3'd6;
      default: return 3'd0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      m_phase = 0; m_pc = 8'h00; m_acc = 8'h00;
      m_z = 1'b0; m_c = 1'b0; m_halt = 1'b0;
      m_ram = ram_init;
    end else begin
      m_iw = rom[m_pc]; m_op = m_iw[11:8]; m_k = m_iw[7:0];
      chk("pc",     32'(instr_addr), 32'(m_pc));
      chk("acc",    32'(acc),        32'(m_acc));
      chk("alu_a",  32'(alu_a),      32'(m_acc));
      chk("z",      32'(flag_z),     32'(m_z));
      chk("c",      32'(flag_c),     32'(m_c));
      chk("halted", 32'(halted),     32'(m_halt));
      chk("we",     32'(mem_we),     32'(!m_halt && m_phase == 2 && m_op == 4'hA && en));
      chk("opr7",   32'(alu_opr == 3'd7), 32'(0));
      if (!m_halt && m_phase == 1) chk("dec_addr", 32'(mem_addr), 32'(m_k));
      if (!m_halt && m_phase == 2) begin
        chk("ex_addr", 32'(mem_addr), 32'(m_k));
        chk("opr",     32'(alu_opr),  32'(exp_opr(m_op)));
        if (m_op >= 4'h1 && m_op <= 4'h5) chk("alu_b", 32'(alu_b), 32'(m_ram[m_k]));
        else if (m_op == 4'h6 || m_op == 4'h7) chk("alu_b", 32'(alu_b), 32'(m_acc));
        else if (m_op == 4'hE) chk("alu_b", 32'(alu_b), 32'(m_k));
        else chk("alu_b", 32'(alu_b), 32'(0));
        if (m_op == 4'hA) chk("wdata", 32'(mem_wdata), 32'(m_acc));
      end
      if (en && !m_halt) begin
        if (m_phase < 2) m_phase++;
        else begin
          m_phase = 0;
          m_jmp = (m_op == 4'hB) || (m_op == 4'hC && m_z) || (m_op == 4'hD && m_c);
          m_alu = 1'b1;
          m_s   = 9'h000;
          case (m_op)
            4'h1: m_s = {1'b0, m_acc} + {1'b0, m_ram[m_k]};
            4'h2: m_s = {1'b0, m_acc} - {1'b0, m_ram[m_k]};
            4'h3: m_s = {1'b0, m_acc & m_ram[m_k]};
            4'h4: m_s = {1'b0, m_acc | m_ram[m_k]};
            4'h5: m_s = {1'b0, m_acc ^ m_ram[m_k]};
            4'h6: m_s = {m_acc, 1'b0};
            4'h7: m_s = {2'b00, m_acc[7:1]};
            4'hE: m_s = {1'b0, m_acc} + {1'b0, m_k};
            default: m_alu = 1'b0;
          endcase
          if (m_alu) begin
            m_acc = m_s[7:0]; m_c = m_s[8]; m_z = (m_s[7:0] == 8'h00);
          end
          if (m_op == 4'h8) m_acc = m_k;
          if (m_op == 4'h9) m_acc = m_ram[m_k];
          if (m_op == 4'hA) m_ram[m_k] = m_acc;
          if (m_op == 4'hF) m_halt = 1'b1;
          else m_pc = m_jmp ? m_k : m_pc + 8'd1;
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic prep();
    rst = 1'b1; en = 1'b1;
    for (int i = 0; i < 256; i++) begin rom[i] = 12'h000; ram_init[i] = 8'h00; end
  endtask

  task automatic go();
    cyc(2);
    rst = 1'b0;
  endtask

  int base;

  initial begin
    prep();
    cyc(2);
    chk("rst_acc", 32'(acc), 32'h00);
    chk("rst_pc",  32'(instr_addr), 32'h00);
    chk("rst_z",   32'(flag_z), 32'd0);
    chk("rst_c",   32'(flag_c), 32'd0);
    chk("rst_hlt", 32'(halted), 32'd0);
    chk("rst_we",  32'(mem_we), 32'd0);

    // LDI 5; ADDI 3; HLT
    prep(); rom[0] = 12'h805; rom[1] = 12'hE03; rom[2] = 12'hF00; go();
    cyc(9);
    chk("p1_acc", 32'(acc), 32'h08);
    chk("p1_z",   32'(flag_z), 32'd0);
    chk("p1_c",   32'(flag_c), 32'd0);
    chk("p1_hlt", 32'(halted), 32'd1);
    chk("p1_pc",  32'(instr_addr), 32'h02);
    cyc(5);
    chk("p1_hold", 32'(instr_addr), 32'h02);

    // LDI FF; ADDI 1; JC 10
    prep(); rom[0] = 12'h8FF; rom[1] = 12'hE01; rom[2] = 12'hD10; rom[16] = 12'hF00; go();
    cyc(9);
    chk("jc_acc", 32'(acc), 32'h00);
    chk("jc_z",   32'(flag_z), 32'd1);
    chk("jc_c",   32'(flag_c), 32'd1);
    chk("jc_pc",  32'(instr_addr), 32'h10);

    // same with ADDI 0: not taken
    prep(); rom[0] = 12'h8FF; rom[1] = 12'hE00; rom[2] = 12'hD10; rom[3] = 12'hF00; go();
    cyc(9);
    chk("nj_c",  32'(flag_c), 32'd0);
    chk("nj_pc", 32'(instr_addr), 32'h03);

    // M[20]=7: LDI 3; SUB 20; STA 21
    prep(); ram_init[8'h20] = 8'h07;
    rom[0] = 12'h803; rom[1] = 12'h220; rom[2] = 12'hA21; rom[3] = 12'hF00; go();
    base = we_cnt;
    cyc(12);
    chk("sub_c",    32'(flag_c), 32'd1);
    chk("sub_mem",  32'(ram[8'h21]), 32'hFC);
    chk("sub_wes",  32'(we_cnt - base), 32'd1);
    chk("sub_wa",   32'(we_addr), 32'h21);
    chk("sub_wd",   32'(we_data), 32'hFC);

    // shifts and flag preservation through LDI
    prep();
    rom[0] = 12'h881; rom[1] = 12'h600; rom[2] = 12'h700; rom[3] = 12'h800;
    rom[4] = 12'h880; rom[5] = 12'h600; rom[6] = 12'h805; rom[7] = 12'hF00; go();
    cyc(6);
    chk("shl_acc", 32'(acc), 32'h02);
    chk("shl_c",   32'(flag_c), 32'd1);
    cyc(3);
    chk("shr_acc", 32'(acc), 32'h01);
    chk("shr_c",   32'(flag_c), 32'd0);
    cyc(12);
    chk("ldi_acc", 32'(acc), 32'h05);
    chk("ldi_z",   32'(flag_z), 32'd1);
    chk("ldi_c",   32'(flag_c), 32'd1);

    // PC wrap and JMP loop
    prep(); rom[0] = 12'hBFF; rom[255] = 12'h000; go();
    cyc(3);  chk("wrap_ff", 32'(instr_addr), 32'hFF);
    cyc(3);  chk("wrap_00", 32'(instr_addr), 32'h00);
    cyc(3);  chk("loop_ff", 32'(instr_addr), 32'hFF);
    cyc(20); chk("loop_run", 32'(halted), 32'd0);

    // freeze during STA EXECUTE
    prep(); rom[0] = 12'h8AB; rom[1] = 12'hA30; rom[2] = 12'hF00; go();
    base = we_cnt;
    cyc(5);
    en = 1'b0;
    cyc(4);
    chk("frz_we",   32'(we_cnt - base), 32'd0);
    chk("frz_pc",   32'(instr_addr), 32'h01);
    chk("frz_addr", 32'(mem_addr), 32'h30);
    chk("frz_mem",  32'(ram[8'h30]), 32'h00);
    en = 1'b1;
    cyc(3);
    chk("frz_once", 32'(we_cnt - base), 32'd1);
    chk("frz_wr",   32'(ram[8'h30]), 32'hAB);

    // reset pulse during DECODE
    prep(); rom[0] = 12'h805; rom[1] = 12'hE03; rom[2] = 12'hF00; go();
    cyc(4);
    chk("pre_acc", 32'(acc), 32'h05);
    rst = 1'b1;
    #1;
    chk("ar_acc", 32'(acc), 32'h00);
    chk("ar_pc",  32'(instr_addr), 32'h00);
    cyc(1);
    rst = 1'b0;
    cyc(9);
    chk("ar_rerun", 32'(acc), 32'h08);
    chk("ar_hlt",   32'(halted), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
